// File: rtl/exp_align_sequencer_pkg.sv
// Shared types and sizing helpers for the exponent-alignment sequencer.
package exp_align_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_SIZE_EXP   = 8;
  localparam int DEF_SIZE_MAN   = 24;
  localparam int DEF_SHIFT_STEP = 4;
  localparam int W              = DEF_SIZE_MAN + 3;

  function automatic int rem_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int REM_W = rem_width(W);

endpackage

// File: rtl/exp_align_sequencer_if.sv
// Operand and result handshake bundle between upstream, the sequencer and the mantissa adder.
interface exp_align_sequencer_if
  import exp_align_sequencer_pkg::*;
#(
  parameter int SIZE_EXP = DEF_SIZE_EXP,
  parameter int SIZE_MAN = DEF_SIZE_MAN
);
  logic                  i_valid;
  logic                  o_ready;
  logic [SIZE_EXP-1:0]   i_exp_a;
  logic [SIZE_EXP-1:0]   i_exp_b;
  logic [SIZE_MAN-1:0]   i_man_a;
  logic [SIZE_MAN-1:0]   i_man_b;
  logic                  o_valid;
  logic                  i_ready;
  logic [SIZE_EXP-1:0]   o_exp_greater;
  logic [SIZE_MAN+2:0]   o_man_greater;
  logic [SIZE_MAN+2:0]   o_man_aligned;
  logic                  o_swap;
  logic                  o_busy;

  modport slave (
    input  i_valid, i_exp_a, i_exp_b, i_man_a, i_man_b, i_ready,
    output o_ready, o_valid, o_exp_greater, o_man_greater, o_man_aligned, o_swap, o_busy
  );

  modport master (
    output i_valid, i_exp_a, i_exp_b, i_man_a, i_man_b, i_ready,
    input  o_ready, o_valid, o_exp_greater, o_man_greater, o_man_aligned, o_swap, o_busy
  );
endinterface

// File: rtl/exp_align_sequencer_step.sv
// One bounded right-shift step of the aligned mantissa with sticky accumulation.
module exp_align_step
  import exp_align_sequencer_pkg::*;
#(
  parameter int WIDTH      = W,
  parameter int RW         = REM_W,
  parameter int SHIFT_STEP = DEF_SHIFT_STEP
) (
  input  logic [WIDTH-1:0] v_in,
  input  logic [RW-1:0]    rem_in,
  output logic [WIDTH-1:0] v_out,
  output logic [RW-1:0]    rem_out
);
  localparam logic [RW-1:0] STEP = RW'(SHIFT_STEP);

  logic [RW-1:0] s;
  logic          sticky;

  // Bit 0 becomes the OR of every bit that falls off plus the old sticky bit.
  always_comb begin
    s      = (rem_in < STEP) ? rem_in : STEP;
    sticky = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i <= int'(s)) sticky = sticky | v_in[i];
    end
    v_out    = v_in >> s;
    v_out[0] = sticky;
    rem_out  = rem_in - s;
  end
endmodule

// File: rtl/exp_align_sequencer.sv
// Operand-alignment controller: picks the larger exponent and shifts the other
// mantissa right by the difference a few bits per cycle, keeping guard/round/sticky.
module exp_align_sequencer
  import exp_align_sequencer_pkg::*;
#(
  parameter int SIZE_EXP   = DEF_SIZE_EXP,
  parameter int SIZE_MAN   = DEF_SIZE_MAN,
  parameter int SHIFT_STEP = DEF_SHIFT_STEP
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  exp_align_sequencer_if.slave bus
);
  localparam int AW  = SIZE_MAN + 3;
  localparam int ARW = rem_width(AW);

  state_e               state_q, state_d;
  logic [SIZE_EXP-1:0]  exp_greater_q, exp_greater_d;
  logic [AW-1:0]        man_greater_q, man_greater_d;
  logic [AW-1:0]        v_q, v_d, v_step;
  logic [ARW-1:0]       rem_q, rem_d, rem_step;
  logic                 swap_q, swap_d;

  logic                 in_swap;
  logic [SIZE_EXP-1:0]  exp_big, exp_small, exp_diff;
  logic [SIZE_MAN-1:0]  man_big, man_small;
  logic [ARW-1:0]       rem_init;

  exp_align_step #(
    .WIDTH      (AW),
    .RW         (ARW),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_step (
    .v_in    (v_q),
    .rem_in  (rem_q),
    .v_out   (v_step),
    .rem_out (rem_step)
  );

  // Distances at or beyond the register width all collapse to "shift everything into sticky".
  always_comb begin
    in_swap   = bus.i_exp_a < bus.i_exp_b;
    exp_big   = in_swap ? bus.i_exp_b : bus.i_exp_a;
    exp_small = in_swap ? bus.i_exp_a : bus.i_exp_b;
    man_big   = in_swap ? bus.i_man_b : bus.i_man_a;
    man_small = in_swap ? bus.i_man_a : bus.i_man_b;
    exp_diff  = exp_big - exp_small;
    if (int'(exp_diff) >= AW) rem_init = ARW'(AW);
    else                      rem_init = ARW'(exp_diff);
  end

  always_comb begin
    state_d       = state_q;
    exp_greater_d = exp_greater_q;
    man_greater_d = man_greater_q;
    v_d           = v_q;
    rem_d         = rem_q;
    swap_d        = swap_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          exp_greater_d = exp_big;
          man_greater_d = {man_big, 3'b000};
          v_d           = {man_small, 3'b000};
          rem_d         = rem_init;
          swap_d        = in_swap;
          state_d       = (rem_init == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        v_d   = v_step;
        rem_d = rem_step;
        if (rem_step == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      exp_greater_q <= '0;
      man_greater_q <= '0;
      v_q           <= '0;
      rem_q         <= '0;
      swap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_greater_q <= exp_greater_d;
      man_greater_q <= man_greater_d;
      v_q           <= v_d;
      rem_q         <= rem_d;
      swap_q        <= swap_d;
    end
  end

  assign bus.o_ready       = (state_q == ST_IDLE);
  assign bus.o_valid       = (state_q == ST_DONE);
  assign bus.o_busy        = (state_q != ST_IDLE);
  assign bus.o_exp_greater = exp_greater_q;
  assign bus.o_man_greater = man_greater_q;
  assign bus.o_man_aligned = v_q;
  assign bus.o_swap        = swap_q;
endmodule

// File: tb/tb_exp_align_sequencer.sv
// Self-checking bench for exp_align_sequencer: directed cases plus randomized operands with stalls.
module tb_exp_align_sequencer;
  localparam int AW = 27;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exp_align_sequencer_if #(.SIZE_EXP(8), .SIZE_MAN(24)) bus ();

  exp_align_sequencer #(.SIZE_EXP(8), .SIZE_MAN(24), .SHIFT_STEP(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checkCount = 0;
  int failCount  = 0;

  logic        expSwap;
  logic [7:0]  expExp;
  logic [26:0] expManG;
  logic [26:0] expManA;
  int          expLat;

  logic        lastSwap;
  logic [7:0]  lastExp;
  logic [26:0] lastManG;
  logic [26:0] lastManA;
  int          lastLat;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: whole-distance shift in one go, sticky = OR of every dropped bit.
  function automatic void refModel(input logic [7:0] ea, input logic [7:0] eb,
                                   input logic [23:0] ma, input logic [23:0] mb,
                                   output logic sw, output logic [7:0] ge,
                                   output logic [26:0] mg, output logic [26:0] al,
                                   output int lat);
    int          d, dc;
    logic [26:0] v;
    logic [26:0] mask;
    sw = (ea < eb);
    ge = sw ? eb : ea;
    mg = {(sw ? mb : ma), 3'b000};
    v  = {(sw ? ma : mb), 3'b000};
    d  = sw ? (int'(eb) - int'(ea)) : (int'(ea) - int'(eb));
    if (d >= AW) begin
      al = (v != 0) ? 27'd1 : 27'd0;
    end else begin
      mask = (27'd1 << d) - 27'd1;
      al   = (v >> d) | (((v & mask) != 0) ? 27'd1 : 27'd0);
    end
    dc  = (d > AW) ? AW : d;
    lat = 1 + (dc + 3) / 4;
  endfunction

  task automatic waitReady();
    int n = 0;
    while (!bus.o_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("ready_before_accept", 32'(bus.o_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] ea, input logic [7:0] eb,
                               input logic [23:0] ma, input logic [23:0] mb,
                               input int stall, input bit junk);
    int cyc;
    refModel(ea, eb, ma, mb, expSwap, expExp, expManG, expManA, expLat);
    waitReady();
    bus.i_exp_a = ea;
    bus.i_exp_b = eb;
    bus.i_man_a = ma;
    bus.i_man_b = mb;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    cyc = 1;
    while (!bus.o_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("latency", 32'(cyc), 32'(expLat));
    checkOutput("o_valid", 32'(bus.o_valid), 32'd1);
    checkOutput("o_swap", 32'(bus.o_swap), 32'(expSwap));
    checkOutput("o_exp_greater", 32'(bus.o_exp_greater), 32'(expExp));
    checkOutput("o_man_greater", 32'(bus.o_man_greater), 32'(expManG));
    checkOutput("o_man_aligned", 32'(bus.o_man_aligned), 32'(expManA));
    checkOutput("done_ready", 32'(bus.o_ready), 32'd0);
    checkOutput("done_busy", 32'(bus.o_busy), 32'd1);
    lastSwap = bus.o_swap;
    lastExp  = bus.o_exp_greater;
    lastManG = bus.o_man_greater;
    lastManA = bus.o_man_aligned;
    lastLat  = cyc;
    for (int k = 0; k < stall; k++) begin
      if (junk) begin
        bus.i_valid = 1'b1;
        bus.i_exp_a = 8'($urandom);
        bus.i_exp_b = 8'($urandom);
        bus.i_man_a = 24'($urandom);
        bus.i_man_b = 24'($urandom);
      end
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(bus.o_valid), 32'd1);
      checkOutput("hold_ready", 32'(bus.o_ready), 32'd0);
      checkOutput("hold_exp", 32'(bus.o_exp_greater), 32'(expExp));
      checkOutput("hold_aligned", 32'(bus.o_man_aligned), 32'(expManA));
      checkOutput("hold_greater", 32'(bus.o_man_greater), 32'(expManG));
      checkOutput("hold_swap", 32'(bus.o_swap), 32'(expSwap));
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    checkOutput("release_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("release_ready", 32'(bus.o_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  ea, eb, tmp;
    logic [23:0] ma, mb;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_exp_a = '0;
    bus.i_exp_b = '0;
    bus.i_man_a = '0;
    bus.i_man_b = '0;
    rst_n = 1'b0;
    #12;
    checkOutput("reset_ready", 32'(bus.o_ready), 32'd1);
    checkOutput("reset_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("reset_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("reset_exp", 32'(bus.o_exp_greater), 32'd0);
    checkOutput("reset_greater", 32'(bus.o_man_greater), 32'd0);
    checkOutput("reset_aligned", 32'(bus.o_man_aligned), 32'd0);
    checkOutput("reset_swap", 32'(bus.o_swap), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(8'h80, 8'h80, 24'h800000, 24'hC00000, 0, 1'b0);
    checkOutput("eq_lat", 32'(lastLat), 32'd1);
    checkOutput("eq_swap", 32'(lastSwap), 32'd0);
    checkOutput("eq_exp", 32'(lastExp), 32'h80);
    checkOutput("eq_greater", 32'(lastManG), 32'h4000000);
    checkOutput("eq_aligned", 32'(lastManA), 32'h6000000);

    applyStimulus(8'h7F, 8'h84, 24'h800003, 24'h800000, 0, 1'b0);
    checkOutput("d5_lat", 32'(lastLat), 32'd3);
    checkOutput("d5_swap", 32'(lastSwap), 32'd1);
    checkOutput("d5_exp", 32'(lastExp), 32'h84);
    checkOutput("d5_aligned", 32'(lastManA), 32'h200001);

    applyStimulus(8'hFE, 8'h01, 24'hFFFFFF, 24'h800000, 0, 1'b0);
    checkOutput("clamp_lat", 32'(lastLat), 32'd8);
    checkOutput("clamp_aligned", 32'(lastManA), 32'h1);

    applyStimulus(8'hFE, 8'h01, 24'hFFFFFF, 24'h000000, 0, 1'b0);
    checkOutput("clamp_zero_lat", 32'(lastLat), 32'd8);
    checkOutput("clamp_zero_aligned", 32'(lastManA), 32'h0);

    applyStimulus(8'h10, 8'h12, 24'hA00000, 24'h900001, 5, 1'b1);
    applyStimulus(8'h20, 8'h20, 24'h812345, 24'hF00000, 0, 1'b0);
    checkOutput("after_bp_aligned", 32'(lastManA), 32'h7800000);
    checkOutput("after_bp_greater", 32'(lastManG), 32'h4091A28);

    waitReady();
    bus.i_exp_a = 8'h90;
    bus.i_exp_b = 8'h7C;
    bus.i_man_a = 24'h800000;
    bus.i_man_b = 24'hABCDEF;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("midshift_busy", 32'(bus.o_busy), 32'd1);
    checkOutput("midshift_valid", 32'(bus.o_valid), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(bus.o_ready), 32'd1);
    checkOutput("abort_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("abort_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("abort_exp", 32'(bus.o_exp_greater), 32'd0);
    checkOutput("abort_greater", 32'(bus.o_man_greater), 32'd0);
    checkOutput("abort_aligned", 32'(bus.o_man_aligned), 32'd0);
    checkOutput("abort_swap", 32'(bus.o_swap), 32'd0);
    #3;
    rst_n = 1'b1;
    applyStimulus(8'h55, 8'h55, 24'hC00000, 24'h800001, 0, 1'b0);
    checkOutput("post_reset_lat", 32'(lastLat), 32'd1);
    checkOutput("post_reset_aligned", 32'(lastManA), 32'h4000008);

    for (int t = 0; t < 1000; t++) begin
      ea = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       eb = 8'($urandom);
        1:       eb = ea;
        default: eb = ea + 8'($urandom_range(0, 30));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        tmp = ea;
        ea  = eb;
        eb  = tmp;
      end
      ma = 24'($urandom) | 24'h800000;
      mb = 24'($urandom) | 24'h800000;
      if ($urandom_range(0, 15) == 0) ma = 24'h0;
      if ($urandom_range(0, 15) == 0) mb = 24'h0;
      if ($urandom_range(0, 7) == 0) mb = 24'h800000 | 24'($urandom_range(0, 7));
      applyStimulus(ea, eb, ma, mb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule

// File: doc/exp_align_sequencer.md
# exp_align_sequencer

Multi-cycle operand-alignment controller for the floating-point add/sub path. It accepts two exponent/mantissa pairs over a valid/ready handshake and selects the greater exponent. It then right-shifts the smaller operand's mantissa by the exponent difference, a bounded number of bits per cycle, accumulating guard/round/sticky. Finally it presents the aligned pair to the mantissa adder stage over a second valid/ready handshake.

## Interface
Parameters:
- SIZE_EXP, 8, exponent width
- SIZE_MAN, 24, mantissa width including hidden bit
- SHIFT_STEP, 4, maximum right-shift distance per cycle (1..SIZE_MAN+3)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  upstream operands valid
- o_ready  out  1  block can accept operands
- i_exp_a, i_exp_b  in  SIZE_EXP  operand exponents
- i_man_a, i_man_b  in  SIZE_MAN  operand mantissas
- o_valid  out  1  aligned result valid
- i_ready  in  1  downstream accepts result
- o_exp_greater  out  SIZE_EXP  larger exponent
- o_man_greater  out  SIZE_MAN+3  larger-exponent mantissa, {man, 3'b000}
- o_man_aligned  out  SIZE_MAN+3  shifted smaller mantissa; the 3 LSBs are guard, round and sticky
- o_swap  out  1  0: exp_a >= exp_b; 1: exp_a < exp_b
- o_busy  out  1  state != IDLE

## Operation
- W = SIZE_MAN+3. Internal registers:
  - rem, the remaining shift distance, ceil(log2(W+1)) bits wide
  - V, the W-bit aligned-mantissa working register
- FSM states: IDLE, SHIFT, DONE. o_ready = (state==IDLE). o_valid = (state==DONE).
- IDLE, on i_valid & o_ready (accept):
  - swap = (i_exp_a < i_exp_b). Equal exponents give swap=0.
  - Register the greater exponent, the greater mantissa (as {man,000}), and V = {smaller man, 000}.
  - d = greater − smaller, computed as an unsigned SIZE_EXP-bit subtraction with no wrap, since greater >= smaller.
  - rem = min(d, W).
  - If rem==0, next state is DONE; otherwise SHIFT.
- SHIFT, each cycle:
  - s = min(rem, SHIFT_STEP).
  - V ← V >> s, with the new V[0] = OR of old V[s:0]. The sticky bit absorbs every dropped bit and the previous sticky.
  - rem ← rem − s.
  - When rem−s == 0, next state is DONE.
- DONE: all outputs held stable. On i_ready, next state is IDLE.
  - Accepts are not overlapped: o_ready=0 in DONE even when i_ready=1.
  - i_valid is ignored outside IDLE.
- A shift distance of d >= W gives o_man_aligned = 0…01 if the smaller mantissa is nonzero, and all zeros otherwise.
- A zero mantissa shifts to all zeros, and sticky stays 0.

## Timing
- Reset (asynchronous, immediate on i_rst_n low):
  - state=IDLE; o_ready=1; o_valid=0; o_busy=0.
  - o_exp_greater, o_man_greater, o_man_aligned and o_swap = 0; rem=0.
- Reset mid-SHIFT or mid-DONE aborts the transaction. No partial result is ever presented.
- Latency from the accept edge to o_valid high is 1 + ceil(min(d,W)/SHIFT_STEP) cycles:
  - d=0: 1 cycle.
  - W=27, step 4: at most 8 cycles.
- Throughput: one transaction per latency + 1 cycles minimum. The DONE→IDLE handshake costs one cycle.
- o_valid stays high and the outputs stay constant until the cycle i_ready is sampled high. o_valid drops on the next edge.
- All outputs are registered. No combinational path exists from i_valid or i_ready to any output except through state.

## Structure
- Shared package: the state enum (IDLE, SHIFT, DONE) and the localparams W = SIZE_MAN+3 and the rem width.
- One natural sub-module, exp_align_step. It is combinational: given V, rem and SHIFT_STEP, it produces the next V (with sticky OR) and the next rem.
- The top level holds the FSM, the capture/swap logic and the exponent subtraction.

## Test plan
SIZE_EXP=8, SIZE_MAN=24, SHIFT_STEP=4, W=27.
- Equal exponents, exp_a=exp_b=0x80, man_a=0x800000, man_b=0xC00000 → o_valid 1 cycle after accept; o_swap=0; o_exp_greater=0x80; o_man_greater=0x4000000; o_man_aligned=0x6000000.
- exp_a=0x7F, exp_b=0x84 (d=5), man_a=0x800003, man_b=0x800000 → o_swap=1; o_exp_greater=0x84; o_man_aligned=0x200001 (sticky set); o_valid 3 cycles after accept.
- exp_a=0xFE, exp_b=0x01, man_b=0x800000 → rem clamped to 27; 7 SHIFT cycles; o_man_aligned=0x0000001; o_valid 8 cycles after accept. Repeat with man_b=0 → o_man_aligned=0.
- Backpressure: hold i_ready=0 for 5 cycles in DONE while driving new i_valid operands → outputs constant, o_ready=0, new operands not captured. Then i_ready=1 → IDLE next cycle, and the next operands are accepted correctly.
- Assert i_rst_n low mid-SHIFT (d=20) → all outputs 0 and o_ready=1 immediately. After release, a d=0 transaction completes in 1 cycle with correct values.
- Randomized: 1000 operand pairs against a reference model of shift-with-sticky and latency, with random i_ready stalls.
